riscv_dbg_ctrl: RTL and testbench

Synthesizable debug access controller for the MPSoC. It replaces the per-core behavioural debug model.
- A single host-side request/response channel serialises STALL, UNSTALL, WRITE and READ commands to any core, or broadcasts STALL/UNSTALL to all cores.
- It latches breakpoint-induced stalls, drives the per-core debug bus strobe, and waits for the core's ack under a timeout.
- It sits between the debug transport (JTAG/UART bridge) and the flattened core array (X*Y*Z*CORES_PER_TILE cores).

---
 rtl/riscv_dbg_ctrl_pkg.sv | 19 +
 rtl/riscv_dbg_ctrl_if.sv | 28 ++
 rtl/riscv_dbg_stall_bank.sv | 19 +
 rtl/riscv_dbg_ctrl.sv | 135 +++++++++++++
 tb/tb_riscv_dbg_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_dbg_ctrl_pkg.sv
// Shared types and defaults for the debug access controller.
package riscv_dbg_ctrl_pkg;

    typedef enum logic [1:0] {
        DBG_STALL   = 2'd0,
        DBG_UNSTALL = 2'd1,
        DBG_WRITE   = 2'd2,
        DBG_READ    = 2'd3
    } dbg_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dbg_state_t;

    localparam int DBG_TIMEOUT = 255;

endpackage

// File: rtl/riscv_dbg_ctrl_if.sv
// Host-side command/response channel of the debug controller.
interface riscv_dbg_ctrl_if #(
    parameter int XLEN = 64,
    parameter int PLEN = 64,
    parameter int CW   = 6
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [1:0]      req_op_i;
    logic            req_bcast_i;
    logic [CW-1:0]   req_core_i;
    logic [PLEN-1:0] req_adr_i;
    logic [XLEN-1:0] req_dat_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_dat_o;
    logic            rsp_err_o;

    modport master (
        output req_valid_i, req_op_i, req_bcast_i, req_core_i, req_adr_i, req_dat_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_bcast_i, req_core_i, req_adr_i, req_dat_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o
    );
endinterface

// File: rtl/riscv_dbg_stall_bank.sv
// Per-core halt latches: set by breakpoint or STALL, cleared by UNSTALL.
module riscv_dbg_stall_bank #(
    parameter int CORES = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [CORES-1:0] bp,
    input  logic [CORES-1:0] set_mask,
    input  logic [CORES-1:0] clr_mask,
    output logic [CORES-1:0] stall_q
);

    // Setting terms are ORed after the clear so a breakpoint beats a same-edge UNSTALL.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) stall_q <= '0;
        else       stall_q <= (stall_q & ~clr_mask) | set_mask | bp;
    end

endmodule

// File: rtl/riscv_dbg_ctrl.sv
// Debug access controller: serialises host STALL/UNSTALL/WRITE/READ onto the core array.
module riscv_dbg_ctrl
    import riscv_dbg_ctrl_pkg::*;
#(
    parameter  int XLEN    = 64,
    parameter  int PLEN    = 64,
    parameter  int CORES   = 64,
    parameter  int TIMEOUT = DBG_TIMEOUT,
    localparam int CW      = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    riscv_dbg_ctrl_if.slave       host,
    input  logic [CORES-1:0]      cpu_bp_i,
    output logic [CORES-1:0]      cpu_stall_o,
    output logic [CORES-1:0]      cpu_stb_o,
    output logic                  cpu_we_o,
    output logic [PLEN-1:0]       cpu_adr_o,
    output logic [XLEN-1:0]       cpu_dat_o,
    input  logic [CORES*XLEN-1:0] cpu_dat_i,
    input  logic [CORES-1:0]      cpu_ack_i,
    output logic [CORES-1:0]      halted_o
);

    localparam int CNTW = $clog2(TIMEOUT + 1);

    dbg_state_t                   state, state_nx;
    dbg_op_t                      op;
    logic [CW-1:0]                core_q;
    logic [CNTW-1:0]              cnt;
    logic [CORES-1:0]             stall_q, set_mask, clr_mask, sel_mask;
    logic [CORES-1:0][XLEN-1:0]   rd_arr;
    logic                         core_ok, ack_hit, tmo, start_acc, rsp_load, rsp_err_nx;
    logic [XLEN-1:0]              rsp_dat_nx;

    assign op       = dbg_op_t'(host.req_op_i);
    assign rd_arr   = cpu_dat_i;
    assign core_ok  = 32'(host.req_core_i) < CORES;
    assign sel_mask = core_ok ? (CORES'(1) << host.req_core_i) : '0;
    assign ack_hit  = cpu_ack_i[core_q];
    assign tmo      = (cnt == CNTW'(TIMEOUT - 1));

    assign host.req_ready_o = (state == IDLE);
    assign host.rsp_valid_o = (state == RESP);
    assign cpu_stall_o      = cpu_bp_i | stall_q;
    assign halted_o         = stall_q;

    riscv_dbg_stall_bank #(.CORES(CORES)) u_stall_bank (
        .clk      (clk),
        .rstn     (rstn),
        .bp       (cpu_bp_i),
        .set_mask (set_mask),
        .clr_mask (clr_mask),
        .stall_q  (stall_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        set_mask   = '0;
        clr_mask   = '0;
        start_acc  = 1'b0;
        rsp_load   = 1'b0;
        rsp_err_nx = 1'b0;
        rsp_dat_nx = '0;
        case (state)
            IDLE: if (host.req_valid_i) begin
                state_nx = RESP;
                rsp_load = 1'b1;
                if (op == DBG_STALL || op == DBG_UNSTALL) begin
                    if (host.req_bcast_i || core_ok) begin
                        if (op == DBG_STALL) set_mask = host.req_bcast_i ? '1 : sel_mask;
                        else                 clr_mask = host.req_bcast_i ? '1 : sel_mask;
                    end else begin
                        rsp_err_nx = 1'b1;
                    end
                end else if (|(stall_q & sel_mask)) begin
                    // Bus access only to a valid, already halted core.
                    state_nx  = ACCESS;
                    rsp_load  = 1'b0;
                    start_acc = 1'b1;
                end else begin
                    rsp_err_nx = 1'b1;
                end
            end
            ACCESS: begin
                if (ack_hit) begin
                    state_nx   = RESP;
                    rsp_load   = 1'b1;
                    rsp_dat_nx = cpu_we_o ? '0 : rd_arr[core_q];
                end else if (tmo) begin
                    state_nx   = RESP;
                    rsp_load   = 1'b1;
                    rsp_err_nx = 1'b1;
                end
            end
            RESP: if (host.rsp_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_q         <= '0;
            cnt            <= '0;
            cpu_stb_o      <= '0;
            cpu_we_o       <= 1'b0;
            cpu_adr_o      <= '0;
            cpu_dat_o      <= '0;
            host.rsp_dat_o <= '0;
            host.rsp_err_o <= 1'b0;
        end else begin
            if (start_acc) begin
                core_q    <= host.req_core_i;
                cnt       <= '0;
                cpu_stb_o <= sel_mask;
                cpu_we_o  <= (op == DBG_WRITE);
                cpu_adr_o <= host.req_adr_i;
                cpu_dat_o <= host.req_dat_i;
            end else if (state == ACCESS) begin
                if (ack_hit || tmo) cpu_stb_o <= '0;
                else                cnt       <= cnt + 1'b1;
            end
            if (rsp_load) begin
                host.rsp_dat_o <= rsp_dat_nx;
                host.rsp_err_o <= rsp_err_nx;
            end
        end
    end

endmodule

// File: tb/tb_riscv_dbg_ctrl.sv
// Directed bench for riscv_dbg_ctrl with a cycle-level expectation model and per-cycle compare.
module tb_riscv_dbg_ctrl;
    import riscv_dbg_ctrl_pkg::*;

    localparam int XLEN    = 64;
    localparam int PLEN    = 64;
    localparam int CORES   = 6;
    localparam int TIMEOUT = 4;
    localparam int CW      = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    riscv_dbg_ctrl_if #(.XLEN(XLEN), .PLEN(PLEN), .CW(CW)) dbg ();

    logic [CORES-1:0]           cpu_bp, cpu_stall, cpu_stb, cpu_ack, halted;
    logic                       cpu_we;
    logic [PLEN-1:0]            cpu_adr;
    logic [XLEN-1:0]            cpu_wdat;
    logic [CORES-1:0][XLEN-1:0] dat_arr;

    riscv_dbg_ctrl #(.XLEN(XLEN), .PLEN(PLEN), .CORES(CORES), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .host        (dbg.slave),
        .cpu_bp_i    (cpu_bp),
        .cpu_stall_o (cpu_stall),
        .cpu_stb_o   (cpu_stb),
        .cpu_we_o    (cpu_we),
        .cpu_adr_o   (cpu_adr),
        .cpu_dat_o   (cpu_wdat),
        .cpu_dat_i   (dat_arr),
        .cpu_ack_i   (cpu_ack),
        .halted_o    (halted)
    );

    int checks = 0;
    int failures = 0;

    // Expected DUT-visible state after the most recent clock edge.
    logic [CORES-1:0] exp_halted = '0;
    logic [CORES-1:0] exp_stb = '0;
    logic             exp_ready = 1'b1;
    logic             exp_rsp_valid = 1'b0;
    logic             exp_err = 1'b0;
    logic [XLEN-1:0]  exp_dat = '0;
    logic             exp_we = 1'b0;
    logic [PLEN-1:0]  exp_adr = '0;
    logic [XLEN-1:0]  exp_wdat = '0;

    int               stb_cycles = 0;
    logic             last_err = 1'b0;
    logic [XLEN-1:0]  last_dat = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("req_ready", 64'(dbg.req_ready_o), 64'(exp_ready));
        chk("halted", 64'(halted), 64'(exp_halted));
        chk("cpu_stall", 64'(cpu_stall), 64'(cpu_bp | exp_halted));
        chk("cpu_stb", 64'(cpu_stb), 64'(exp_stb));
        chk("rsp_valid", 64'(dbg.rsp_valid_o), 64'(exp_rsp_valid));
        if (exp_rsp_valid) begin
            chk("rsp_err", 64'(dbg.rsp_err_o), 64'(exp_err));
            chk("rsp_dat", dbg.rsp_dat_o, exp_dat);
        end
        if (exp_stb != '0) begin
            chk("cpu_we", 64'(cpu_we), 64'(exp_we));
            chk("cpu_adr", cpu_adr, exp_adr);
            chk("cpu_dat", cpu_wdat, exp_wdat);
        end
        if (cpu_stb != '0) stb_cycles++;
        if (dbg.rsp_valid_o) begin
            last_err = dbg.rsp_err_o;
            last_dat = dbg.rsp_dat_o;
        end
    end

    // Advance one clock; breakpoints present at the edge latch into the halt model.
    task automatic tick();
        @(posedge clk);
        if (rstn) exp_halted = exp_halted | cpu_bp;
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic bc, input int core,
                       input logic [63:0] adr, input logic [63:0] wd, input int ack_dly,
                       input logic [63:0] rdat, input int hold,
                       input logic [CORES-1:0] bp_acc, input logic [CORES-1:0] noise_ack);
        logic [CORES-1:0] m;
        logic [CORES-1:0] tgt;
        stb_cycles = 0;
        m = (core < CORES) ? (CORES'(1) << core) : '0;
        for (int i = 0; i < CORES; i++)
            dat_arr[i] = (i == core) ? rdat : {32'hBAD0_0000, 32'(i)};
        dbg.req_valid_i = 1'b1;
        dbg.req_op_i    = op;
        dbg.req_bcast_i = bc;
        dbg.req_core_i  = CW'(core);
        dbg.req_adr_i   = adr;
        dbg.req_dat_i   = wd;
        cpu_bp          = bp_acc;
        tick();
        dbg.req_valid_i = 1'b0;
        cpu_bp          = '0;
        exp_ready       = 1'b0;
        exp_err         = 1'b0;
        exp_dat         = '0;
        if (op == 2'd0 || op == 2'd1) begin
            tgt = bc ? '1 : m;
            if (!bc && core >= CORES) exp_err = 1'b1;
            else if (op == 2'd0)      exp_halted = exp_halted | tgt;
            else                      exp_halted = (exp_halted & ~tgt) | bp_acc;
            exp_rsp_valid = 1'b1;
        end else if (core >= CORES || (exp_halted & m) == '0) begin
            exp_err       = 1'b1;
            exp_rsp_valid = 1'b1;
        end else begin
            exp_stb  = m;
            exp_we   = (op == 2'd2);
            exp_adr  = adr;
            exp_wdat = wd;
            for (int k = 0; k < TIMEOUT; k++) begin
                cpu_ack = noise_ack;
                if (k == ack_dly) cpu_ack = cpu_ack | m;
                tick();
                cpu_ack = '0;
                if (k == ack_dly) begin
                    exp_stb       = '0;
                    exp_dat       = (op == 2'd3) ? rdat : '0;
                    exp_rsp_valid = 1'b1;
                    break;
                end
                if (k == TIMEOUT - 1) begin
                    exp_stb       = '0;
                    exp_err       = 1'b1;
                    exp_rsp_valid = 1'b1;
                end
            end
        end
        repeat (hold) tick();
        dbg.rsp_ready_i = 1'b1;
        tick();
        dbg.rsp_ready_i = 1'b0;
        exp_rsp_valid   = 1'b0;
        exp_ready       = 1'b1;
    endtask

    initial begin
        dbg.req_valid_i = 1'b0;
        dbg.req_op_i    = '0;
        dbg.req_bcast_i = 1'b0;
        dbg.req_core_i  = '0;
        dbg.req_adr_i   = '0;
        dbg.req_dat_i   = '0;
        dbg.rsp_ready_i = 1'b0;
        cpu_bp          = '0;
        cpu_ack         = '0;
        dat_arr         = '0;
        repeat (3) tick();
        chk("rst_stb", 64'(cpu_stb), 64'h0);
        chk("rst_rsp_dat", dbg.rsp_dat_o, 64'h0);
        rstn = 1'b1;
        tick();

        // READ on a running core is refused without touching the bus.
        cmd(2'd3, 1'b0, 3, 64'h100, 64'h0, 0, 64'h55, 0, '0, '0);
        chk("t1_stb_cycles", 64'(stb_cycles), 64'd0);
        chk("t1_err", 64'(last_err), 64'd1);
        chk("t1_dat", last_dat, 64'h0);

        cmd(2'd0, 1'b0, 3, 64'h0, 64'h0, -1, 64'h0, 0, '0, '0);
        chk("t2_halted", 64'(halted), 64'h8);
        cmd(2'd2, 1'b0, 3, 64'h100, 64'hDEAD_BEEF, 2, 64'h0, 0, '0, '0);
        chk("t2_stb_cycles", 64'(stb_cycles), 64'd3);
        chk("t2_err", 64'(last_err), 64'd0);

        cmd(2'd3, 1'b0, 3, 64'h100, 64'h0, 0, 64'h1234, 5, '0, '0);
        chk("t3_dat", last_dat, 64'h1234);
        chk("t3_err", 64'(last_err), 64'd0);
        chk("t3_stb_cycles", 64'(stb_cycles), 64'd1);

        cpu_bp = 6'b10_0000;
        tick();
        cpu_bp = '0;
        repeat (2) tick();
        chk("t4_bp_latch", 64'(halted), 64'h28);
        cmd(2'd1, 1'b0, 5, 64'h0, 64'h0, -1, 64'h0, 0, 6'b10_0000, '0);
        chk("t4_bp_wins", 64'(halted), 64'h28);
        cmd(2'd1, 1'b0, 5, 64'h0, 64'h0, -1, 64'h0, 0, '0, '0);
        chk("t4_unstall", 64'(halted), 64'h08);

        cmd(2'd0, 1'b1, 0, 64'h0, 64'h0, -1, 64'h0, 0, '0, '0);
        chk("t5_bcast_stall", 64'(halted), 64'h3F);
        cmd(2'd3, 1'b0, 0, 64'h40, 64'h0, -1, 64'h77, 1, '0, 6'b00_0010);
        chk("t5_stb_cycles", 64'(stb_cycles), 64'd4);
        chk("t5_err", 64'(last_err), 64'd1);
        chk("t5_dat", last_dat, 64'h0);
        cmd(2'd1, 1'b1, 0, 64'h0, 64'h0, -1, 64'h0, 0, '0, '0);
        chk("t5_bcast_unstall", 64'(halted), 64'h0);

        // Core index beyond the array.
        cmd(2'd0, 1'b0, 7, 64'h0, 64'h0, -1, 64'h0, 0, '0, '0);
        chk("oor_stall_err", 64'(last_err), 64'd1);
        chk("oor_stall_halted", 64'(halted), 64'h0);
        cmd(2'd0, 1'b1, 7, 64'h0, 64'h0, -1, 64'h0, 0, '0, '0);
        cmd(2'd3, 1'b0, 7, 64'h0, 64'h0, 0, 64'h99, 0, '0, '0);
        chk("oor_read_err", 64'(last_err), 64'd1);
        chk("oor_read_stb", 64'(stb_cycles), 64'd0);

        // Reset in the middle of an access.
        dbg.req_valid_i = 1'b1;
        dbg.req_op_i    = 2'd2;
        dbg.req_bcast_i = 1'b0;
        dbg.req_core_i  = CW'(2);
        dbg.req_adr_i   = 64'h200;
        dbg.req_dat_i   = 64'hCAFE;
        tick();
        dbg.req_valid_i = 1'b0;
        exp_ready = 1'b0;
        exp_stb   = 6'b00_0100;
        exp_we    = 1'b1;
        exp_adr   = 64'h200;
        exp_wdat  = 64'hCAFE;
        tick();
        rstn       = 1'b0;
        exp_stb    = '0;
        exp_halted = '0;
        exp_ready  = 1'b1;
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        chk("t6_ready", 64'(dbg.req_ready_o), 64'd1);
        chk("t6_halted", 64'(halted), 64'h0);
        chk("t6_rsp_valid", 64'(dbg.rsp_valid_o), 64'd0);
        cmd(2'd0, 1'b0, 1, 64'h0, 64'h0, -1, 64'h0, 0, '0, '0);
        chk("t6_post_stall", 64'(halted), 64'h2);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
